// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the wait-state data memory.
// Holds the access FSM state enum, default geometry and the byte-offset helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DMEM_BASE_ADDR = 1024;
  localparam int DMEM_DEPTH     = 64;

  // log2 of bytes per word: shift from byte offset to word index
  function automatic int byte_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage, byte-lane sync write, sync read.
// Ports: clk, we/be/wdata (write), re/rdata (read), idx (shared word index).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we && be[i]) begin
        mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_ws.sv
// data_memory_ws: MEM-stage data memory with WAIT_CYCLES wait states.
// Ports: clk, rst (sync, active-low); mem_r_en/mem_w_en/address/data/byte_en
// request; busy/done/rd_valid/err status; data_memory_out read data.
// Build macro DMEM_BOUNDS_CHECK_EN adds range faults (err); else index wraps.
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = DMEM_DEPTH,
  parameter int BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                busy,
  output logic                done,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   data_memory_out,
  output logic                err
);

  localparam int LANES = DATA_W / 8;
  localparam int SHIFT = byte_shift(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic ZERO_WS = (WAIT_CYCLES == 0);
  localparam logic [3:0] WS_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             state;
  logic [3:0]         cnt;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [LANES-1:0]   be_q;
  logic               zero_q;
  logic [DATA_W-1:0]  rdata;

  logic               in_idle;
  logic               req;
  logic               cur_wr;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  cur_data;
  logic [LANES-1:0]   cur_be;
  logic [ADDR_W-1:0]  off;
  logic [IDX_W-1:0]   idx;
  logic               fault;
  logic               fire;
  logic               we;
  logic               re;
  logic               unused_off;

  assign in_idle = (state == IDLE);
  assign req     = mem_w_en | mem_r_en;

  // Zero-wait accesses complete on the accept edge, so the
  // array sees live inputs in IDLE and captured ones later.
  assign cur_wr   = in_idle ? mem_w_en : wr_q;
  assign cur_addr = in_idle ? address  : addr_q;
  assign cur_data = in_idle ? data     : data_q;
  assign cur_be   = in_idle ? byte_en  : be_q;

  assign off        = cur_addr - ADDR_W'(BASE_ADDR);
  assign idx        = off[SHIFT +: IDX_W];
  assign unused_off = ^off;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign fault = (cur_addr < ADDR_W'(BASE_ADDR)) ||
                 ((off >> SHIFT) >= ADDR_W'(DEPTH));
`else
  assign fault = 1'b0;
`endif

  // Edge that enters DONE; gated by rst so a reset drops the access
  assign fire = rst &
    ((in_idle & req & ZERO_WS) | ((state == WAIT) & (cnt == 4'd0)));

  assign we = fire & cur_wr & ~fault;
  assign re = fire & ~cur_wr & ~fault;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .idx   (idx),
    .be    (cur_be),
    .wdata (cur_data),
    .rdata (rdata)
  );

  // Array read register has no reset; zero_q forces 0 after
  // reset and after a faulting read until a good read lands.
  assign data_memory_out = zero_q ? '0 : rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      done     <= fire;
      rd_valid <= fire & ~cur_wr;
      err      <= fire & fault;
      if (fire && !cur_wr) begin
        zero_q <= fault;
      end
      unique case (state)
        IDLE: begin
          if (req) begin
            wr_q   <= mem_w_en;
            addr_q <= address;
            data_q <= data;
            be_q   <= byte_en;
            busy   <= 1'b1;
            cnt    <= WS_LOAD;
            state  <= ZERO_WS ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws: directed bench for data_memory_ws.
// Instance 0 runs WAIT_CYCLES=0, instance 1 runs WAIT_CYCLES=3.
module tb_data_memory_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  r_en;
  logic [1:0]  w_en;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  rv;
  logic [1:0]  err;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] dout  [2];
  logic [3:0]  be    [2];

  int nvec = 0;
  int nmis = 0;

  int          g_lat;
  int          g_bsy;
  logic        g_rv;
  logic        g_err;
  logic        g_after;
  logic [31:0] g_dout;

  always #5 clk = ~clk;

  data_memory_ws #(.WAIT_CYCLES(0)) u_z (
    .clk             (clk),
    .rst             (rst),
    .mem_r_en        (r_en[0]),
    .mem_w_en        (w_en[0]),
    .address         (addr[0]),
    .data            (wdata[0]),
    .byte_en         (be[0]),
    .busy            (busy[0]),
    .done            (done[0]),
    .rd_valid        (rv[0]),
    .data_memory_out (dout[0]),
    .err             (err[0])
  );

  data_memory_ws #(.WAIT_CYCLES(3)) u_w (
    .clk             (clk),
    .rst             (rst),
    .mem_r_en        (r_en[1]),
    .mem_w_en        (w_en[1]),
    .address         (addr[1]),
    .data            (wdata[1]),
    .byte_en         (be[1]),
    .busy            (busy[1]),
    .done            (done[1]),
    .rd_valid        (rv[1]),
    .data_memory_out (dout[1]),
    .err             (err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access; inputs are scrambled every busy cycle to show
  // that only the captured request matters.
  task automatic acc(input int d, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] dt,
                     input logic [3:0] b);
    @(negedge clk);
    w_en[d] = w; r_en[d] = r; addr[d] = a; wdata[d] = dt; be[d] = b;
    g_lat = 0;
    g_bsy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      g_lat++;
      if (busy[d]) g_bsy++;
      if (done[d]) break;
      w_en[d] = ~w; r_en[d] = ~r; addr[d] = a + 4;
      wdata[d] = ~dt; be[d] = ~b;
    end
    g_rv   = rv[d];
    g_err  = err[d];
    g_dout = dout[d];
    w_en[d] = 1'b0;
    r_en[d] = 1'b0;
    @(negedge clk);
    g_after = done[d] | busy[d];
  endtask

  task automatic expect_acc(input string t, input int lat,
                            input logic erv, input logic eerr,
                            input logic [31:0] ed);
    chk({t, ".lat"},   g_lat,   lat);
    chk({t, ".busy"},  g_bsy,   lat);
    chk({t, ".rv"},    g_rv,    erv);
    chk({t, ".err"},   g_err,   eerr);
    chk({t, ".dout"},  g_dout,  ed);
    chk({t, ".after"}, g_after, 1'b0);
  endtask

  initial begin
    logic seen;
    rst = 1'b0;
    r_en = '0;
    w_en = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d.busy", d), busy[d], 1'b0);
      chk($sformatf("rst%0d.done", d), done[d], 1'b0);
      chk($sformatf("rst%0d.rv", d),   rv[d],   1'b0);
      chk($sformatf("rst%0d.err", d),  err[d],  1'b0);
      chk($sformatf("rst%0d.dout", d), dout[d], 32'h0);
    end
    rst = 1'b1;

    acc(0, 1, 0, 1024, 32'hDEADBEEF, 4'hF);
    expect_acc("t1w", 1, 0, 0, 32'h0);
    acc(0, 0, 1, 1024, 32'h0, 4'h0);
    expect_acc("t1r", 1, 1, 0, 32'hDEADBEEF);

    acc(1, 1, 0, 1028, 32'h12345678, 4'hF);
    expect_acc("t2w", 4, 0, 0, 32'h0);
    acc(1, 0, 1, 1028, 32'h0, 4'h0);
    expect_acc("t2r", 4, 1, 0, 32'h12345678);

    acc(1, 1, 0, 1032, 32'h11223344, 4'hF);
    expect_acc("t3pre", 4, 0, 0, 32'h12345678);
    acc(1, 1, 0, 1032, 32'hAABBCCDD, 4'b0101);
    expect_acc("t3be", 4, 0, 0, 32'h12345678);
    acc(1, 0, 1, 1032, 32'h0, 4'h0);
    expect_acc("t3r", 4, 1, 0, 32'h11BB33DD);

    acc(1, 1, 1, 1036, 32'h5, 4'hF);
    expect_acc("t4rw", 4, 0, 0, 32'h11BB33DD);
    acc(1, 0, 1, 1036, 32'h0, 4'h0);
    expect_acc("t4r", 4, 1, 0, 32'h5);

    acc(1, 1, 0, 1040, 32'hCAFE0001, 4'hF);
    expect_acc("t5pre", 4, 0, 0, 32'h5);
    @(negedge clk);
    w_en[1] = 1'b1; addr[1] = 1040; wdata[1] = 32'h77; be[1] = 4'hF;
    @(negedge clk);
    chk("t5.inwait", busy[1], 1'b1);
    w_en[1] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t5.busy", busy[1], 1'b0);
    chk("t5.done", done[1], 1'b0);
    chk("t5.rv",   rv[1],   1'b0);
    chk("t5.err",  err[1],  1'b0);
    chk("t5.dout", dout[1], 32'h0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | done[1];
    end
    chk("t5.nodone", seen, 1'b0);
    acc(1, 0, 1, 1040, 32'h0, 4'h0);
    expect_acc("t5r", 4, 1, 0, 32'hCAFE0001);

    acc(1, 1, 0, 1024, 32'h0BADF00D, 4'hF);
    expect_acc("t6w0", 4, 0, 0, 32'hCAFE0001);
    acc(1, 1, 0, 1276, 32'h63636363, 4'hF);
    expect_acc("t6w63", 4, 0, 0, 32'hCAFE0001);
`ifdef DMEM_BOUNDS_CHECK_EN
    acc(1, 1, 0, 1020, 32'h99, 4'hF);
    expect_acc("t6flw", 4, 0, 1, 32'hCAFE0001);
    acc(1, 0, 1, 1280, 32'h0, 4'h0);
    expect_acc("t6flr", 4, 1, 1, 32'h0);
    acc(1, 0, 1, 1276, 32'h0, 4'h0);
    expect_acc("t6r63", 4, 1, 0, 32'h63636363);
    acc(1, 0, 1, 1024, 32'h0, 4'h0);
    expect_acc("t6r0", 4, 1, 0, 32'h0BADF00D);
`else
    acc(1, 0, 1, 1280, 32'h0, 4'h0);
    expect_acc("t6wrap", 4, 1, 0, 32'h0BADF00D);
    acc(1, 0, 1, 1276, 32'h0, 4'h0);
    expect_acc("t6r63", 4, 1, 0, 32'h63636363);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
